// File: rtl/tagged_token_demux.sv
// Splits a tagged {tag, payload} token stream into per-flux first-word-fall-through FIFOs.
// A single early-warning full flag is returned to the producer.
module tagged_token_demux #(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = (FLUX > 2) ? $clog2(FLUX) : 1,
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_port_write,
  input  logic [WIDTH-1:0]           in_port_datain,
  output logic                       in_port_full,
  input  logic [FLUX-1:0]            out_port_read,
  output logic [FLUX-1:0]            out_port_empty,
  output logic [FLUX*DATA_WIDTH-1:0] out_port_dataout,
  output logic [FLUX-1:0]            overflow,
  output logic                       bad_tag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(DEPTH - 1);

  logic [TAG_WIDTH-1:0]  tag;
  logic [DATA_WIDTH-1:0] payload;
  logic                  tag_ok;
  logic [FLUX-1:0]       almost_full;
  logic                  bad_tag_q, bad_tag_d;

  assign tag     = in_port_datain[WIDTH-1:DATA_WIDTH];
  assign payload = in_port_datain[DATA_WIDTH-1:0];

  // Only a tag field wider than needed can carry an out-of-range flux number.
  generate
    if ((1 << TAG_WIDTH) > FLUX) begin : g_tag_range
      assign tag_ok = (tag < TAG_WIDTH'(FLUX));
    end else begin : g_tag_all
      assign tag_ok = 1'b1;
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < FLUX; gi++) begin : g_flux
      logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0]      count_q, count_d;
      logic                  ovf_q, ovf_d;
      logic [DATA_WIDTH-1:0] mem_q [DEPTH];
      logic                  hit, push, pop;

      assign hit  = in_port_write && tag_ok && (tag == TAG_WIDTH'(gi));
      // Acceptance looks only at the pre-edge count; a same-cycle pop never frees room.
      assign push = hit && (count_q != CNT_FULL);
      assign pop  = out_port_read[gi] && (count_q != '0);

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (hit && (count_q == CNT_FULL));
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
          ovf_q    <= 1'b0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
          ovf_q    <= ovf_d;
        end
      end

      // Storage is not reset; stale entries are masked by the count.
      always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= payload;
      end

      assign out_port_empty[gi] = (count_q == '0);
      assign out_port_dataout[gi*DATA_WIDTH +: DATA_WIDTH] =
        (count_q != '0) ? mem_q[rd_ptr_q] : '0;
      assign overflow[gi]    = ovf_q;
      assign almost_full[gi] = (count_q >= CNT_AFULL);
    end
  endgenerate

  assign bad_tag_d = bad_tag_q | (in_port_write && !tag_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bad_tag_q <= 1'b0;
    else      bad_tag_q <= bad_tag_d;
  end

  assign bad_tag = bad_tag_q;
  // Raised one entry early so a producer reacting a cycle late never overruns.
  assign in_port_full = |almost_full;

endmodule

// File: tb/tb_tagged_token_demux.sv
// Directed bench for tagged_token_demux: a FLUX=2 instance plus a FLUX=3 instance for bad tags.
module tb_tagged_token_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        wr = 1'b0;
  logic [8:0]  din = '0;
  logic        full;
  logic [1:0]  rd = '0;
  logic [1:0]  empty;
  logic [15:0] dout;
  logic [1:0]  ovf;
  logic        bad;

  logic        wr3 = 1'b0;
  logic [9:0]  din3 = '0;
  logic        full3;
  logic [2:0]  rd3 = '0;
  logic [2:0]  empty3;
  logic [23:0] dout3;
  logic [2:0]  ovf3;
  logic        bad3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tagged_token_demux #(.FLUX(2), .DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_port_write(wr), .in_port_datain(din), .in_port_full(full),
    .out_port_read(rd), .out_port_empty(empty), .out_port_dataout(dout),
    .overflow(ovf), .bad_tag(bad)
  );

  tagged_token_demux #(.FLUX(3), .DATA_WIDTH(8), .TAG_WIDTH(2), .DEPTH(4)) dut3 (
    .clk(clk), .rst(rst),
    .in_port_write(wr3), .in_port_datain(din3), .in_port_full(full3),
    .out_port_read(rd3), .out_port_empty(empty3), .out_port_dataout(dout3),
    .overflow(ovf3), .bad_tag(bad3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // Reset held for three clocks
    repeat (3) cyc();
    chk("rst_empty", 32'(empty), 32'h3);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_bad", 32'(bad), 32'h0);
    chk("rst_empty3", 32'(empty3), 32'h7);
    rst = 1'b1;
    cyc();

    // Steering
    wr = 1'b1; din = {1'b1, 8'd4};
    cyc();
    $display("steer: wrote tag1 payload 4");
    chk("steer_empty_after_t1", 32'(empty), 32'h1);
    din = {1'b0, 8'd4};
    cyc();
    $display("steer: wrote tag0 payload 4");
    wr = 1'b0;
    chk("steer_empty", 32'(empty), 32'h0);
    chk("steer_dout", 32'(dout), 32'h0404);
    rd = 2'b11;
    cyc();
    rd = 2'b00;
    $display("steer: popped both");
    chk("steer_pop_empty", 32'(empty), 32'h3);
    chk("steer_pop_dout", 32'(dout), 32'h0);

    // Fill flux 0
    wr = 1'b1; din = {1'b0, 8'h11};
    cyc();
    din = {1'b0, 8'h22};
    cyc();
    $display("full: two tag0 tokens written");
    chk("full_at2", 32'(full), 32'h0);
    din = {1'b0, 8'h33};
    cyc();
    $display("full: third tag0 token written");
    chk("full_at3", 32'(full), 32'h1);
    din = {1'b0, 8'h44};
    cyc();
    $display("full: fourth tag0 token written");
    chk("full_at4", 32'(full), 32'h1);
    chk("full_ovf_at4", 32'(ovf), 32'h0);
    chk("full_head0", 32'(dout[7:0]), 32'h11);
    din = {1'b0, 8'h55};
    cyc();
    $display("full: fifth tag0 token written");
    chk("full_ovf_at5", 32'(ovf), 32'h1);
    din = {1'b1, 8'h66};
    cyc();
    wr = 1'b0;
    $display("full: tag1 token written while flux0 full");
    chk("full_t1_empty", 32'(empty), 32'h0);
    chk("full_t1_head", 32'(dout[15:8]), 32'h66);
    rd = 2'b10;
    cyc();
    rd = 2'b00;
    chk("full_t1_popped", 32'(empty), 32'h2);

    // Simultaneous write+pop at count 4: write dropped
    wr = 1'b1; din = {1'b0, 8'h77}; rd = 2'b01;
    cyc();
    wr = 1'b0;
    $display("simul: write+pop on full flux0");
    chk("simul_head22", 32'(dout[7:0]), 32'h22);
    chk("simul_full_cnt3", 32'(full), 32'h1);
    cyc();
    chk("simul_head33", 32'(dout[7:0]), 32'h33);
    cyc();
    chk("simul_head44", 32'(dout[7:0]), 32'h44);
    cyc();
    rd = 2'b00;
    $display("simul: drained flux0");
    chk("simul_drained", 32'(empty), 32'h3);
    chk("simul_drained_dout", 32'(dout), 32'h0);
    chk("simul_drained_full", 32'(full), 32'h0);

    // Simultaneous write+pop at count 0: write lands, pop ignored
    wr = 1'b1; din = {1'b0, 8'h99}; rd = 2'b01;
    cyc();
    wr = 1'b0; rd = 2'b00;
    $display("simul: write+pop on empty flux0");
    chk("simul0_empty", 32'(empty), 32'h2);
    chk("simul0_head", 32'(dout[7:0]), 32'h99);
    rd = 2'b01;
    cyc();
    rd = 2'b00;
    chk("simul0_popped", 32'(empty), 32'h3);

    // Order and pointer wrap on flux 1
    for (int k = 1; k <= 10; k++) begin
      wr = 1'b1; din = {1'b1, 8'(k)}; rd = 2'b10;
      cyc();
      $display("order: wrote tag1 payload %0d head=%0d", k, dout[15:8]);
      chk("order_head", 32'(dout[15:8]), 32'(k));
    end
    wr = 1'b0;
    cyc();
    rd = 2'b00;
    chk("order_empty", 32'(empty), 32'h3);
    chk("order_ovf", 32'(ovf), 32'h1);

    // Asynchronous reset mid-traffic
    wr = 1'b1;
    din = {1'b0, 8'hA1}; cyc();
    din = {1'b0, 8'hA2}; cyc();
    din = {1'b0, 8'hA3}; cyc();
    wr = 1'b0;
    chk("mid_full_before", 32'(full), 32'h1);
    #2 rst = 1'b0;
    #1;
    $display("async reset asserted mid-cycle");
    chk("mid_empty", 32'(empty), 32'h3);
    chk("mid_full", 32'(full), 32'h0);
    chk("mid_dout", 32'(dout), 32'h0);
    chk("mid_ovf", 32'(ovf), 32'h0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("mid_after_release", 32'(empty), 32'h3);

    // Bad tag on the three-flux instance
    wr3 = 1'b1; din3 = {2'd2, 8'hC3};
    cyc();
    $display("bad: tag2 payload 0xc3");
    chk("bad_t2_empty", 32'(empty3), 32'h3);
    chk("bad_t2_head", 32'(dout3[23:16]), 32'hC3);
    chk("bad_t2_flag", 32'(bad3), 32'h0);
    din3 = {2'd3, 8'hEE};
    cyc();
    wr3 = 1'b0;
    $display("bad: tag3 payload 0xee");
    chk("bad_flag", 32'(bad3), 32'h1);
    chk("bad_empty", 32'(empty3), 32'h3);
    chk("bad_dout", 32'(dout3), 32'hC30000);
    chk("bad_ovf", 32'(ovf3), 32'h0);
    cyc();
    chk("bad_sticky", 32'(bad3), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
